// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, frame width and the
// clocks-per-bit calculation used by both the transmitter and the receiver.
package uart_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } txState_t;

   // Truncating division, so the real line rate is at or slightly above nominal.
   function automatic int clksPerBit(input int sysClkFreq, input int baudRate);
      return sysClkFreq / baudRate;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: pulses bitDone_o for one cycle every pCLKS_PER_BIT cycles
// while enabled, and restarts from zero whenever it is disabled or reset.
module uart_baud_gen #(
   parameter int pCLKS_PER_BIT = 10
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic enable_i,
   output logic bitDone_o
);

   localparam int CNT_W = $clog2(pCLKS_PER_BIT);
   localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(pCLKS_PER_BIT - 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (!enable_i || count_q == LAST_COUNT) begin
         count_d = '0;
      end else begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign bitDone_o = enable_i && (count_q == LAST_COUNT);

endmodule

// File: rtl/uart_tx.sv
// 8-bit UART transmitter (8N1 / 8N2). Defining UART_TX_PARITY_EN inserts a
// parity bit after the data bits; pPARITY_ODD then selects odd parity.
module uart_tx
   import uart_pkg::*;
#(
   parameter int pBAUD_RATE    = 9600,
   parameter int pSYS_CLK_FREQ = 100000000,
   parameter int pSTOP_BITS    = 1
`ifdef UART_TX_PARITY_EN
   ,
   parameter int pPARITY_ODD   = 0
`endif
) (
   input  logic       sys_clk,
   input  logic       rst_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx,
   output logic       tx_busy
);

   localparam int CLKS_PER_BIT = clksPerBit(pSYS_CLK_FREQ, pBAUD_RATE);
   localparam int IDX_W = $clog2(DATA_BITS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
   localparam logic LAST_STOP = (pSTOP_BITS == 2) ? 1'b1 : 1'b0;

   if (CLKS_PER_BIT < 2) begin : gBadClksPerBit
      $error("uart_tx: CLKS_PER_BIT must be at least 2");
   end
   if (pSTOP_BITS != 1 && pSTOP_BITS != 2) begin : gBadStopBits
      $error("uart_tx: pSTOP_BITS must be 1 or 2");
   end

   txState_t             state_q, state_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic [IDX_W-1:0]     bitIdx_q, bitIdx_d;
   logic                 stopIdx_q, stopIdx_d;
   logic                 tx_q, tx_d;
   logic                 bitDone;

`ifdef UART_TX_PARITY_EN
   logic parityBit;
   assign parityBit = (^data_q) ^ (pPARITY_ODD != 0);
`endif

   // The line value for the next bit is decided together with the state
   // change, so tx always leaves a flop and never sees an input directly.
   always_comb begin
      state_d   = state_q;
      data_d    = data_q;
      bitIdx_d  = bitIdx_q;
      stopIdx_d = stopIdx_q;
      tx_d      = tx_q;
      case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (tx_valid) begin
               data_d    = tx_data;
               bitIdx_d  = '0;
               stopIdx_d = 1'b0;
               tx_d      = 1'b0;
               state_d   = START;
            end
         end
         START: begin
            if (bitDone) begin
               tx_d    = data_q[bitIdx_q];
               state_d = DATA;
            end
         end
         DATA: begin
            if (bitDone) begin
               if (bitIdx_q == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                  tx_d    = parityBit;
                  state_d = PARITY;
`else
                  tx_d    = 1'b1;
                  state_d = STOP;
`endif
               end else begin
                  bitIdx_d = bitIdx_q + 1'b1;
                  tx_d     = data_q[bitIdx_q + 1'b1];
               end
            end
         end
         PARITY: begin
            if (bitDone) begin
               tx_d    = 1'b1;
               state_d = STOP;
            end
         end
         STOP: begin
            if (bitDone) begin
               if (stopIdx_q == LAST_STOP) begin
                  state_d = IDLE;
               end else begin
                  stopIdx_d = 1'b1;
               end
            end
         end
         default: begin
            tx_d    = 1'b1;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         data_q    <= '0;
         bitIdx_q  <= '0;
         stopIdx_q <= 1'b0;
         tx_q      <= 1'b1;
      end else begin
         state_q   <= state_d;
         data_q    <= data_d;
         bitIdx_q  <= bitIdx_d;
         stopIdx_q <= stopIdx_d;
         tx_q      <= tx_d;
      end
   end

   uart_baud_gen #(
      .pCLKS_PER_BIT(CLKS_PER_BIT)
   ) uBaudGen (
      .clk_i    (sys_clk),
      .rst_ni   (rst_n),
      .enable_i (tx_busy),
      .bitDone_o(bitDone)
   );

   assign tx       = tx_q;
   assign tx_ready = (state_q == IDLE);
   assign tx_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: a one-stop-bit and a two-stop-bit instance are
// compared cycle by cycle against a frame model built from bit lists.
module tb_uart_tx;

   localparam int SYS_FREQ = 1000000;
   localparam int BAUD     = 100000;
   localparam int CPB      = 10;
`ifdef UART_TX_PARITY_EN
   localparam int PAR_BITS = 1;
`else
   localparam int PAR_BITS = 0;
`endif
   localparam int LEN1 = (10 + PAR_BITS) * CPB;
   localparam int LEN2 = (11 + PAR_BITS) * CPB;

   logic       sys_clk = 1'b0;
   logic       rst_n;
   logic [7:0] tx_data;
   logic       tx_valid, tx_ready, tx, tx_busy;
   logic       valid2, ready2, tx2, busy2;

   int checks   = 0;
   int failures = 0;

   logic txLog[$];
   logic readyLog[$];
   logic busyLog[$];
   logic expTx[$];
   logic expReady[$];

   always #5 sys_clk = ~sys_clk;

   uart_tx #(
      .pBAUD_RATE   (BAUD),
      .pSYS_CLK_FREQ(SYS_FREQ),
      .pSTOP_BITS   (1)
`ifdef UART_TX_PARITY_EN
      ,
      .pPARITY_ODD  (0)
`endif
   ) dut (
      .sys_clk (sys_clk),
      .rst_n   (rst_n),
      .tx_data (tx_data),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready),
      .tx      (tx),
      .tx_busy (tx_busy)
   );

   uart_tx #(
      .pBAUD_RATE   (BAUD),
      .pSYS_CLK_FREQ(SYS_FREQ),
      .pSTOP_BITS   (2)
`ifdef UART_TX_PARITY_EN
      ,
      .pPARITY_ODD  (1)
`endif
   ) dut2 (
      .sys_clk (sys_clk),
      .rst_n   (rst_n),
      .tx_data (tx_data),
      .tx_valid(valid2),
      .tx_ready(ready2),
      .tx      (tx2),
      .tx_busy (busy2)
   );

   // Frame model: start bit, data LSB first, optional parity, stop bits;
   // every bit is held for CPB cycles. Appends to the expectation queues.
   function automatic void modelFrame(input logic [7:0] b, input int stopBits, input int oddPar);
      logic bits[$];
      int   ones = 0;
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) begin
         bits.push_back(b[i]);
         ones += b[i] ? 1 : 0;
      end
      if (PAR_BITS == 1) bits.push_back(((ones + oddPar) % 2) == 1);
      for (int s = 0; s < stopBits; s++) bits.push_back(1'b1);
      foreach (bits[k]) begin
         repeat (CPB) begin
            expTx.push_back(bits[k]);
            expReady.push_back(1'b0);
         end
      end
   endfunction

   function automatic logic expTxAt(input int j);
      return (j < expTx.size()) ? expTx[j] : 1'b1;
   endfunction

   function automatic logic expReadyAt(input int j);
      return (j < expReady.size()) ? expReady[j] : 1'b1;
   endfunction

   function automatic int firstTxMismatch();
      foreach (txLog[j]) if (txLog[j] !== expTxAt(j)) return j;
      return -1;
   endfunction

   function automatic int firstHandshakeMismatch();
      foreach (readyLog[j]) begin
         if (readyLog[j] !== expReadyAt(j) || busyLog[j] !== ~expReadyAt(j)) return j;
      end
      return -1;
   endfunction

   // Waits (bounded) for the selected instance to be ready, then offers a byte.
   task automatic startFrame(input bit second, input logic [7:0] b);
      int guard = 0;
      while ((second ? ready2 : tx_ready) !== 1'b1 && guard < 1000) begin
         @(posedge sys_clk);
         #1;
         guard++;
      end
      checks++;
      if (guard >= 1000) begin
         failures++;
         $display("[TB] FAIL wait_ready: got ready=%b required 1 within 1000 cycles", second ? ready2 : tx_ready);
      end
      tx_data = b;
      if (second) valid2 = 1'b1;
      else tx_valid = 1'b1;
   endtask

   // Records one sample per cycle, #1 after each rising edge; sample 0 follows the acceptance edge.
   task automatic captureFrame(input bit second, input int nCycles, input int dropAt,
                               input int chgAt, input logic [7:0] chgData);
      txLog.delete();
      readyLog.delete();
      busyLog.delete();
      for (int j = 0; j < nCycles; j++) begin
         @(posedge sys_clk);
         #1;
         if (j == dropAt) begin
            tx_valid = 1'b0;
            valid2   = 1'b0;
         end
         if (j == chgAt) tx_data = chgData;
         txLog.push_back(second ? tx2 : tx);
         readyLog.push_back(second ? ready2 : tx_ready);
         busyLog.push_back(second ? busy2 : tx_busy);
      end
   endtask

   task automatic test_reset();
      int bad = 0;
      rst_n = 1'b0;
      repeat (3) @(posedge sys_clk);
      #1;
      checks++;
      if (tx !== 1'b1) begin failures++; $display("[TB] FAIL reset_tx: got %b required 1", tx); end
      checks++;
      if (tx_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready: got %b required 1", tx_ready); end
      checks++;
      if (tx_busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b required 0", tx_busy); end
      rst_n = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(posedge sys_clk);
         #1;
         if (tx !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0 || tx2 !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("[TB] FAIL idle_hold: got %0d bad idle cycles required 0", bad);
      end
   endtask

   task automatic test_frame(input logic [7:0] b, input string name);
      int m;
      expTx.delete();
      expReady.delete();
      modelFrame(b, 1, 0);
      startFrame(1'b0, b);
      captureFrame(1'b0, LEN1 + 2, 0, -1, 8'h00);
      m = firstTxMismatch();
      checks++;
      if (m >= 0) begin
         failures++;
         $display("[TB] FAIL %s_tx byte=%h cycle %0d: got %b required %b", name, b, m, txLog[m], expTxAt(m));
      end
      m = firstHandshakeMismatch();
      checks++;
      if (m >= 0) begin
         failures++;
         $display("[TB] FAIL %s_handshake byte=%h cycle %0d: got ready=%b busy=%b required ready=%b",
                  name, b, m, readyLog[m], busyLog[m], expReadyAt(m));
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 5; i++) test_frame(8'($urandom_range(0, 255)), "random");
   endtask

   task automatic test_back_to_back();
      int m;
      expTx.delete();
      expReady.delete();
      modelFrame(8'hA5, 1, 0);
      expTx.push_back(1'b1);
      expReady.push_back(1'b1);
      modelFrame(8'h3C, 1, 0);
      startFrame(1'b0, 8'hA5);
      captureFrame(1'b0, 2 * LEN1 + 3, LEN1 + 1, 30, 8'h3C);
      m = firstTxMismatch();
      checks++;
      if (m >= 0) begin
         failures++;
         $display("[TB] FAIL b2b_tx cycle %0d: got %b required %b", m, txLog[m], expTxAt(m));
      end
      m = firstHandshakeMismatch();
      checks++;
      if (m >= 0) begin
         failures++;
         $display("[TB] FAIL b2b_handshake cycle %0d: got ready=%b required %b", m, readyLog[m], expReadyAt(m));
      end
   endtask

   task automatic test_reset_midframe();
      startFrame(1'b0, 8'($urandom_range(0, 255)));
      captureFrame(1'b0, 35, 0, -1, 8'h00);
      rst_n = 1'b0;
      @(posedge sys_clk);
      #1;
      rst_n = 1'b1;
      checks++;
      if (tx !== 1'b1) begin failures++; $display("[TB] FAIL abort_tx: got %b required 1", tx); end
      checks++;
      if (tx_busy !== 1'b0) begin failures++; $display("[TB] FAIL abort_busy: got %b required 0", tx_busy); end
      checks++;
      if (tx_ready !== 1'b1) begin failures++; $display("[TB] FAIL abort_ready: got %b required 1", tx_ready); end
      test_frame(8'hFF, "after_abort");
   endtask

   task automatic test_two_stop();
      int m;
      int busyCount = 0;
      expTx.delete();
      expReady.delete();
      modelFrame(8'h00, 2, 1);
      startFrame(1'b1, 8'h00);
      captureFrame(1'b1, LEN2 + 2, 0, -1, 8'h00);
      m = firstTxMismatch();
      checks++;
      if (m >= 0) begin
         failures++;
         $display("[TB] FAIL two_stop_tx cycle %0d: got %b required %b", m, txLog[m], expTxAt(m));
      end
      foreach (busyLog[j]) if (busyLog[j] === 1'b1) busyCount++;
      checks++;
      if (busyCount != LEN2) begin
         failures++;
         $display("[TB] FAIL two_stop_length: got %0d busy cycles required %0d", busyCount, LEN2);
      end
   endtask

`ifdef UART_TX_PARITY_EN
   task automatic test_parity();
      startFrame(1'b0, 8'h07);
      captureFrame(1'b0, LEN1 + 2, 0, -1, 8'h00);
      checks++;
      if (txLog[9 * CPB + 5] !== 1'b1) begin
         failures++;
         $display("[TB] FAIL parity_even: got %b required 1", txLog[9 * CPB + 5]);
      end
      startFrame(1'b1, 8'h07);
      captureFrame(1'b1, LEN2 + 2, 0, -1, 8'h00);
      checks++;
      if (txLog[9 * CPB + 5] !== 1'b0) begin
         failures++;
         $display("[TB] FAIL parity_odd: got %b required 0", txLog[9 * CPB + 5]);
      end
   endtask
`endif

   initial begin
      rst_n    = 1'b0;
      tx_data  = 8'h00;
      tx_valid = 1'b0;
      valid2   = 1'b0;
      test_reset();
      test_frame(8'h59, "frame_59");
      test_random();
      test_back_to_back();
      test_reset_midframe();
      test_two_stop();
`ifdef UART_TX_PARITY_EN
      test_parity();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout required completion");
      $fatal(1, "[TB] simulation time limit reached");
   end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- 8-bit UART transmitter: serialises one byte per handshake into an 8N1 frame on the `tx` line.
- Upstream neighbour of the UART receiver top; `tx` connects directly to the receiver's `rx` input.
- Sits in the same `sys_clk` domain as the receiver and uses the same baud/clock parameters, so loopback needs no glue.

Parameters:
- pBAUD_RATE, 9600, line bit rate in bits/s.
- pSYS_CLK_FREQ, 100000000, `sys_clk` frequency in Hz.
- pSTOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- sys_clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- tx_data  in  8  byte to send; sampled only on acceptance.
- tx_valid  in  1  upstream offers `tx_data`.
- tx_ready  out  1  block can accept a byte this cycle.
- tx  out  1  serial line; idle high.
- tx_busy  out  1  frame in progress; high from the start bit through the last stop bit.

Behaviour:
- CLKS_PER_BIT = pSYS_CLK_FREQ / pBAUD_RATE, integer division, truncating (10416 at defaults).
  - Elaboration `$error` if CLKS_PER_BIT < 2, or if pSTOP_BITS is not 1 or 2.
- Reset (rst_n=0 at a clock edge):
  - tx=1, tx_ready=1, tx_busy=0.
  - State IDLE; bit counter and baud counter cleared.
- Reset asserted mid-frame aborts the frame at that edge: tx returns high, byte discarded, no partial retransmit.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- IDLE:
  - tx_ready=1, tx=1.
  - Acceptance when tx_valid=1 and tx_ready=1 at a clock edge: latch tx_data into the shift register, go to START.
  - tx_ready drops and tx goes low in the cycle after acceptance.
- Bit timing:
  - Every bit (start, data, parity, each stop) is driven for exactly CLKS_PER_BIT cycles.
  - Baud counter runs 0..CLKS_PER_BIT-1 and reloads to 0 on each bit boundary.
- DATA: 8 bits, LSB first; bit index 0..7; leaves DATA after index 7 completes.
- STOP: tx=1 for pSTOP_BITS*CLKS_PER_BIT cycles, then IDLE.
- Frame duration, acceptance edge to return to IDLE: (10 + pSTOP_BITS - 1 [+1 parity]) * CLKS_PER_BIT cycles.
- Back-to-back frames: tx_valid held high is accepted in the first IDLE cycle, so there is exactly one extra high cycle between the last stop bit and the next start bit.
- tx_valid or tx_data changes while busy are ignored; there is no buffering and no error flag.
- tx is registered; no combinational path from any input to tx.
- tx_busy = (state != IDLE), registered with the state.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted after DATA.
  - It drives XOR of the 8 data bits for even parity, inverted when parameter pPARITY_ODD=1 (default 0).
  - The parity bit lasts CLKS_PER_BIT cycles.
- Undefined: PARITY state and pPARITY_ODD do not exist; frame is 8N1/8N2 only.

Decomposition:
- Shared package uart_pkg holds:
  - tx state enum typedef (IDLE, START, DATA, PARITY, STOP).
  - DATA_BITS=8 constant.
  - A function computing CLKS_PER_BIT from frequency and baud, reused by the receiver.
- One sub-module: uart_baud_gen.
  - A counter that emits a 1-cycle bit_done pulse every CLKS_PER_BIT cycles while enabled.
  - Clears synchronously on disable or reset.

Test Plan (pSYS_CLK_FREQ=1000000, pBAUD_RATE=100000, so CLKS_PER_BIT=10, unless noted):
- Reset then idle 50 cycles -> tx=1, tx_ready=1, tx_busy=0 throughout.
- Send 8'h59 (0101_1001) -> tx waveform: 0, 1,0,0,1,1,0,1,0, 1, each bit 10 cycles; tx_ready low for 100 cycles; loopback into the receiver top yields data_out=8'h59.
- tx_valid held high with 8'hA5 then 8'h3C -> two frames; start of second frame exactly 1 cycle after the end of the first stop bit; tx_data changes mid-frame have no effect.
- rst_n low for 1 cycle at cycle 35 of a frame -> tx=1 the cycle after, tx_busy=0, tx_ready=1; next byte 8'hFF transmits cleanly.
- pSTOP_BITS=2, send 8'h00 -> stop high for 20 cycles; frame total 110 cycles.
- UART_TX_PARITY_EN defined, pPARITY_ODD=0, send 8'h07 -> parity bit 1, frame 110 cycles; pPARITY_ODD=1 -> parity bit 0.
